sdrc_req_arb: RTL and testbench
===============================

// Module: sdrc_req_arb
// PURPOSE
//  Round-robin arbiter that shares the single SDRAM request-generator
//  port between NP application requesters.
//  - Latches the winning port's request and presents it downstream.
//  - Returns a per-port acknowledge.
//  - Exports the granted port index so the data path can steer write/read data.
//  Sits between the application ports and sdrc_req_gen.
// PARAMETERS
//  NP      4   number of requesting ports (2..8)
//  APP_AW  30  application address width
//  APP_RW  9   request length width (words)
//  ID_W    4   request ID width (matches SDR_REQ_ID_W)
//  PW      2   localparam, $clog2(NP), grant index width
// PORTS
//  clk          in   1         clock; all logic on rising edge
//  reset_n      in   1         reset, synchronous, active-low
//  p_req        in   NP        per-port request; held until p_ack
//  p_id         in   NP*ID_W   per-port request ID, port k at [k*ID_W +: ID_W]
//  p_addr       in   NP*APP_AW per-port address, packed the same way
//  p_len        in   NP*APP_RW per-port length, packed the same way
//  p_wrap       in   NP        per-port wrap mode
//  p_wr_n       in   NP        per-port 0=write, 1=read
//  p_ack        out  NP        one-hot, 1-cycle accept pulse to the granted port
//  req          out  1         downstream request
//  req_id       out  ID_W      downstream ID
//  req_addr     out  APP_AW    downstream address
//  req_len      out  APP_RW    downstream length
//  req_wrap     out  1         downstream wrap
//  req_wr_n     out  1         downstream direction
//  req_ack      in   1         downstream accept, 1 cycle
//  gnt_idx      out  PW        index of the last granted port; stable until the next grant
//  arb_busy     out  1         1 while in state GNT
// BEHAVIOUR
//  Reset (reset_n=0 at an edge):
//  - state=IDLE; req, p_ack, arb_busy = 0; gnt_idx=0.
//  - req_id/addr/len/wrap/wr_n = 0; last_gnt = NP-1, so port 0 wins first.
//  - Applies mid-transaction: the pending grant is dropped and no p_ack is issued.
//  FSM states IDLE, GNT:
//  - IDLE: if |p_req, pick winner w = first requesting port after last_gnt,
//    searching cyclically, and go to GNT.
//    - At that edge, register all p_* fields of w into req_*; gnt_idx <= w; last_gnt <= w.
//  - GNT: req=1, arb_busy=1, and req_* hold constant.
//    - When req_ack=1: p_ack[gnt_idx]=1 combinationally in the same cycle,
//      then next state is IDLE.
//  - req_ack while in IDLE is ignored; p_ack stays 0.
//  Latency and throughput:
//  - p_req rises in cycle 0 (IDLE) -> req=1 in cycle 1.
//  - req_ack in cycle n -> earliest next req in cycle n+2 (1 idle bubble).
//  Requester rules:
//  - A requester deasserts p_req, or presents a new request, in the cycle after p_ack.
//  - Payload changes on a granted port before p_ack are not observed (payload is latched).
//  Other rules:
//  - Non-granted ports may raise or drop p_req at any time; no effect until the next IDLE.
//  - At most one p_ack bit is set per cycle; p_ack is never set outside GNT.
//  - Fairness: with all ports requesting continuously, grant order is 0,1,..,NP-1,0,...
//  - No combinational path from p_* to req_*; p_ack depends on req_ack only.
// CONFIGURATION
//  SDRC_ARB_PRIO_EN defined:
//  - Port 0 is strict high priority: whenever p_req[0]=1 in IDLE, port 0 wins.
//  - Remaining ports are round-robin among themselves; their pointer is not
//    advanced by port 0 grants.
//  SDRC_ARB_PRIO_EN undefined:
//  - Pure round-robin across all NP ports as above.
// TESTING
//  Single port: p_req=0100, addr=0x1234, len=8, wr_n=0 -> req in next cycle
//   with req_addr=0x1234, req_len=8, gnt_idx=2; req_ack -> p_ack=0100 same cycle.
//  All 4 ports requesting continuously, req_ack 2 cycles after each req ->
//   gnt_idx sequence 0,1,2,3,0,1; one idle cycle between grants.
//  Port 1 changes p_addr to 0xFFFF while granted -> req_addr keeps the latched value.
//  reset_n=0 while in GNT with req=1 -> req=0 next cycle, no p_ack pulse;
//   first grant after reset goes to port 0.
//  PRIO_EN: p_req=1111 held -> order 0,0,0,...; drop p_req[0] -> 1,2,3,1,...;
//   without PRIO_EN -> 0,1,2,3.
//  Spurious req_ack in IDLE -> p_ack stays 0000, state remains IDLE.

Source files
------------

// File: rtl/sdrc_req_arb.sv
// Round-robin arbiter that shares the SDRAM request-generator port between NP requesters.
// Define SDRC_ARB_PRIO_EN to give port 0 strict priority over the round-robin ports.
module sdrc_req_arb #(
  parameter int NP     = 4,
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int ID_W   = 4,
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NP-1:0]        p_req,
  input  logic [NP*ID_W-1:0]   p_id,
  input  logic [NP*APP_AW-1:0] p_addr,
  input  logic [NP*APP_RW-1:0] p_len,
  input  logic [NP-1:0]        p_wrap,
  input  logic [NP-1:0]        p_wr_n,
  output logic [NP-1:0]        p_ack,
  output logic                 req,
  output logic [ID_W-1:0]      req_id,
  output logic [APP_AW-1:0]    req_addr,
  output logic [APP_RW-1:0]    req_len,
  output logic                 req_wrap,
  output logic                 req_wr_n,
  input  logic                 req_ack,
  output logic [PW-1:0]        gnt_idx,
  output logic                 arb_busy
);

`ifdef SDRC_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic {IDLE, GNT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] last_gnt;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          win_vld;

  // Scan from farthest to nearest so the port closest after last_gnt overrides.
  always_comb begin
    win_vld = |p_req;
    win_idx = '0;
    cand    = '0;
    for (int i = NP; i >= 1; i--) begin
      cand = PW'((int'(last_gnt) + i) % NP);
      if (p_req[cand] && !(PRIO_EN && cand == '0))
        win_idx = cand;
    end
    if (PRIO_EN && p_req[0])
      win_idx = '0;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    arb_busy  = 1'b0;
    p_ack     = '0;
    case (state)
      IDLE: begin
        if (win_vld)
          state_nxt = GNT;
      end
      GNT: begin
        req      = 1'b1;
        arb_busy = 1'b1;
        if (req_ack) begin
          p_ack[gnt_idx] = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_gnt <= PW'(NP - 1);
      gnt_idx  <= '0;
      req_id   <= '0;
      req_addr <= '0;
      req_len  <= '0;
      req_wrap <= 1'b0;
      req_wr_n <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        gnt_idx  <= win_idx;
        req_id   <= p_id[int'(win_idx)*ID_W +: ID_W];
        req_addr <= p_addr[int'(win_idx)*APP_AW +: APP_AW];
        req_len  <= p_len[int'(win_idx)*APP_RW +: APP_RW];
        req_wrap <= p_wrap[win_idx];
        req_wr_n <= p_wr_n[win_idx];
        // A priority grant to port 0 leaves the round-robin pointer alone.
        if (!(PRIO_EN && win_idx == '0))
          last_gnt <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Scoreboard bench for sdrc_req_arb: randomized requesters against a grant-order reference model.
module tb_sdrc_req_arb;
  localparam int NP = 4;
  localparam int AW = 30;
  localparam int RW = 9;
  localparam int IW = 4;
  localparam int PW = 2;

`ifdef SDRC_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NP-1:0]    p_req;
  logic [NP*IW-1:0] p_id;
  logic [NP*AW-1:0] p_addr;
  logic [NP*RW-1:0] p_len;
  logic [NP-1:0]    p_wrap, p_wr_n, p_ack;
  logic             req, req_wrap, req_wr_n, req_ack, arb_busy;
  logic [IW-1:0]    req_id;
  logic [AW-1:0]    req_addr;
  logic [RW-1:0]    req_len;
  logic [PW-1:0]    gnt_idx;

  sdrc_req_arb #(.NP(NP), .APP_AW(AW), .APP_RW(RW), .ID_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .p_req(p_req), .p_id(p_id), .p_addr(p_addr),
    .p_len(p_len), .p_wrap(p_wrap), .p_wr_n(p_wr_n), .p_ack(p_ack), .req(req),
    .req_id(req_id), .req_addr(req_addr), .req_len(req_len), .req_wrap(req_wrap),
    .req_wr_n(req_wr_n), .req_ack(req_ack), .gnt_idx(gnt_idx), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] idx;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [RW-1:0] len;
    logic          wrap;
    logic          wr_n;
  } txn_t;

  txn_t          txn_q[$];
  logic [NP-1:0] ack_q[$];
  bit            req_q[$];
  int            obs_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            m_busy = 0;
  int            m_gnt  = 0;
  int            m_last = NP - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Winner = lowest requesting index above the last grant, else lowest requesting index.
  function automatic int pick(input logic [NP-1:0] r, input int last, output int new_last);
    int lo, hi, first;
    lo = -1; hi = -1;
    if (PRIO && r[0]) begin
      new_last = last;
      return 0;
    end
    first = PRIO ? 1 : 0;
    for (int k = NP - 1; k >= first; k--)
      if (r[k]) begin
        lo = k;
        if (k > last) hi = k;
      end
    new_last = (hi >= 0) ? hi : lo;
    return new_last;
  endfunction

  // Reference model: evaluates each cycle's inputs and queues the expected responses.
  always @(negedge clk) begin
    txn_t t;
    int   w, nl;
    #1;
    req_q.push_back(m_busy);
    if (!reset_n) begin
      ack_q.push_back('0);
      m_busy = 0;
      m_last = NP - 1;
    end else if (m_busy) begin
      ack_q.push_back(req_ack ? NP'(1 << m_gnt) : '0);
      if (req_ack) m_busy = 0;
    end else begin
      ack_q.push_back('0);
      if (|p_req) begin
        w      = pick(p_req, m_last, nl);
        m_last = nl;
        t.idx  = PW'(w);
        t.id   = p_id[w*IW +: IW];
        t.addr = p_addr[w*AW +: AW];
        t.len  = p_len[w*RW +: RW];
        t.wrap = p_wrap[w];
        t.wr_n = p_wr_n[w];
        txn_q.push_back(t);
        m_busy = 1;
        m_gnt  = w;
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  bit req_prev = 0;
  always @(negedge clk) begin
    txn_t t;
    #2;
    if (req_q.size() > 0) begin
      t.wrap = req_q.pop_front();
      chk("req", 64'(req), 64'(t.wrap));
      chk("arb_busy", 64'(arb_busy), 64'(t.wrap));
    end
    if (ack_q.size() > 0) chk("p_ack", 64'(p_ack), 64'(ack_q.pop_front()));
    if (req === 1'b1 && !req_prev) begin
      if (txn_q.size() == 0) begin
        chk("unexpected_grant", 64'(1), 64'(0));
      end else begin
        t = txn_q.pop_front();
        chk("gnt_idx", 64'(gnt_idx), 64'(t.idx));
        chk("req_id", 64'(req_id), 64'(t.id));
        chk("req_addr", 64'(req_addr), 64'(t.addr));
        chk("req_len", 64'(req_len), 64'(t.len));
        chk("req_wrap", 64'(req_wrap), 64'(t.wrap));
        chk("req_wr_n", 64'(req_wr_n), 64'(t.wr_n));
      end
      obs_q.push_back(int'(gnt_idx));
    end
    req_prev = (req === 1'b1);
  end

  task automatic rand_payload();
    for (int k = 0; k < NP; k++) begin
      p_id[k*IW +: IW]   = IW'($urandom);
      p_addr[k*AW +: AW] = AW'($urandom);
      p_len[k*RW +: RW]  = RW'($urandom);
      p_wrap[k]          = 1'($urandom);
      p_wr_n[k]          = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_ack = 1'b0; p_req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Holds mask requesting, acks each grant on its second req cycle.
  task automatic grants(input logic [NP-1:0] mask, input int n);
    int got, hi, budget;
    got = 0; hi = 0; budget = 0;
    while (got < n && budget < 200) begin
      @(negedge clk);
      budget++;
      p_req = mask;
      rand_payload();
      if (req === 1'b1) hi++; else hi = 0;
      req_ack = (hi == 2);
      if (hi == 2) begin got++; hi = 0; end
    end
    if (got < n) chk("grant_timeout", 64'(got), 64'(n));
    @(negedge clk);
    p_req = '0; req_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_seq(input string nm, input int exp[6], input int n);
    chk({nm, "_count"}, 64'(obs_q.size()), 64'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++)
      chk(nm, 64'(obs_q[i]), 64'(exp[i]));
  endtask

  initial begin
    int exp_seq[6];
    int budget;
    reset_n = 1'b0; p_req = '0; p_id = '0; p_addr = '0; p_len = '0;
    p_wrap = '0; p_wr_n = '0; req_ack = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_p_ack", 64'(p_ack), 64'(0));
    chk("rst_gnt_idx", 64'(gnt_idx), 64'(0));
    chk("rst_req_addr", 64'(req_addr), 64'(0));
    chk("rst_req_len", 64'(req_len), 64'(0));
    chk("rst_req_id", 64'(req_id), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester on port 2; payload changes while granted must not leak.
    @(negedge clk);
    p_req = 4'b0100;
    p_addr[2*AW +: AW] = AW'(32'h1234); p_len[2*RW +: RW] = RW'(8);
    p_wr_n[2] = 1'b0; p_id[2*IW +: IW] = 4'h5;
    @(negedge clk);
    p_addr[2*AW +: AW] = AW'(32'hFFFF);
    #3;
    chk("single_req_addr", 64'(req_addr), 64'(32'h1234));
    chk("single_gnt_idx", 64'(gnt_idx), 64'(2));
    @(negedge clk);
    req_ack = 1'b1;
    #3;
    chk("single_p_ack", 64'(p_ack), 64'(4'b0100));
    @(negedge clk);
    req_ack = 1'b0; p_req = '0;

    // Spurious req_ack while idle.
    repeat (3) begin
      @(negedge clk);
      req_ack = 1'b1;
    end
    @(negedge clk);
    req_ack = 1'b0;

    // Fairness with all ports requesting.
    do_reset();
    obs_q.delete();
    grants(4'b1111, 6);
    exp_seq = PRIO ? '{0, 0, 0, 0, 0, 0} : '{0, 1, 2, 3, 0, 1};
    chk_seq("order_all", exp_seq, 6);

    // Port 0 silent; the prio build's rr pointer was never moved by port 0.
    obs_q.delete();
    grants(4'b1110, 4);
    exp_seq = PRIO ? '{1, 2, 3, 1, 0, 0} : '{2, 3, 1, 2, 0, 0};
    chk_seq("order_no_p0", exp_seq, 4);

    // Reset while granted: no ack, and port 0 wins first afterwards.
    @(negedge clk);
    p_req = 4'b1111;
    budget = 0;
    while (req !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_reset_req_seen", 64'(req), 64'(1));
    reset_n = 1'b0; req_ack = 1'b0;
    @(negedge clk);
    #3;
    chk("mid_reset_req_drop", 64'(req), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    obs_q.delete();
    grants(4'b1111, 1);
    exp_seq = '{0, 0, 0, 0, 0, 0};
    chk_seq("after_reset_first", exp_seq, 1);

    // Randomized requesters, acks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NP; k++)
        p_req[k] = (m_busy && k == m_gnt) ? 1'b1 : ($urandom_range(0, 3) == 0);
      rand_payload();
      req_ack = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      if (!reset_n) req_ack = 1'b0;
    end

    @(negedge clk);
    reset_n = 1'b1; p_req = '0; req_ack = 1'b1;
    repeat (4) @(negedge clk);
    req_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("txn_queue_drained", 64'(txn_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
